// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Clock/reset manager for the local 100 MHz domain. Holds the
//                MMCMs in reset, waits for a filtered lock, then releases the
//                downstream domain resets one at a time. MMCMs that fail to
//                lock are retried. Any loss of lock once domains are being
//                released forces every domain back into reset and replays
//                the whole sequence.
//  Ports       :
//    clkIn           in   1            local clock, all flops on posedge
//    rstIn           in   1            synchronous active-high reset
//    lockedIn        in   NUM_PLL      MMCM locked flags (asynchronous)
//    pllRstOut       out  NUM_PLL      MMCM resets, all driven together
//    domRstOut       out  NUM_DOMAINS  domain resets, bit 0 released first
//    allReadyOut     out  1            high only in RUN
//    lockLossCntOut  out  8            saturating count of lock losses
//    timeoutCntOut   out  8            saturating count of lock timeouts
//    stateOut        out  2            0=PLL_RST 1=WAIT_LOCK 2=RELEASE 3=RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_PLL        = 2,
    parameter int NUM_DOMAINS    = 3,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 8,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STAGE_DELAY    = 32
) (
    input  logic                   clkIn,
    input  logic                   rstIn,
    input  logic [NUM_PLL-1:0]     lockedIn,
    output logic [NUM_PLL-1:0]     pllRstOut,
    output logic [NUM_DOMAINS-1:0] domRstOut,
    output logic                   allReadyOut,
    output logic [7:0]             lockLossCntOut,
    output logic [7:0]             timeoutCntOut,
    output logic [1:0]             stateOut
);

    // One shared cycle counter serves the PLL reset hold, the lock timeout
    // and the release staging; only one of them is active in any state.
    localparam int STAGE_LAST = STAGE_DELAY * NUM_DOMAINS - 1;
    localparam int MAX_A      = (PLL_RST_CYCLES - 1 > LOCK_TIMEOUT - 1) ?
                                (PLL_RST_CYCLES - 1) : (LOCK_TIMEOUT - 1);
    localparam int CNT_MAX    = (MAX_A > STAGE_LAST) ? MAX_A : STAGE_LAST;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;
    localparam int FILT_W     = $clog2(LOCK_FILTER) + 1;

    localparam logic [CNT_W-1:0]  PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STAGE_END = CNT_W'(STAGE_LAST);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PLL-1:0]     sync1_q, sync2_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FILT_W-1:0]      filt_q, filt_d;
    logic [NUM_PLL-1:0]     pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;
    logic [7:0]             to_cnt_q, to_cnt_d;

    logic                   all_locked;
    logic [NUM_DOMAINS-1:0] stage_hit;

    assign all_locked = &sync2_q;

    // Domain i is released at the end of the RELEASE cycle whose counter
    // value is STAGE_DELAY*(i+1)-1, so bits fall STAGE_DELAY cycles apart.
    generate
        for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_stage
            localparam logic [CNT_W-1:0] STAGE_AT = CNT_W'(STAGE_DELAY * (i + 1) - 1);
            assign stage_hit[i] = (cnt_q == STAGE_AT);
        end
    endgenerate

    // Two-flop synchroniser for the asynchronous lock flags.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= lockedIn;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            filt_q     <= '0;
            pll_rst_q  <= '1;
            dom_rst_q  <= '1;
            ready_q    <= 1'b0;
            loss_cnt_q <= 8'd0;
            to_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            pll_rst_q  <= pll_rst_d;
            dom_rst_q  <= dom_rst_d;
            ready_q    <= ready_d;
            loss_cnt_q <= loss_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        filt_d     = filt_q;
        pll_rst_d  = pll_rst_q;
        dom_rst_d  = dom_rst_q;
        ready_d    = ready_q;
        loss_cnt_d = loss_cnt_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            ST_PLL_RST: begin
                pll_rst_d = '1;
                dom_rst_d = '1;
                ready_d   = 1'b0;
                filt_d    = '0;
                if (cnt_q == PLL_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                // A completed lock filter takes precedence over a timeout
                // landing on the same cycle.
                if (all_locked && (filt_q == FILT_LAST)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    filt_d  = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_PLL_RST;
                    cnt_d     = '0;
                    filt_d    = '0;
                    pll_rst_d = '1;
                    to_cnt_d  = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    filt_d = all_locked ? filt_q + FILT_W'(1) : '0;
                end
            end

            ST_RELEASE: begin
                if (!all_locked) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    pll_rst_d  = '1;
                    dom_rst_d  = '1;
                    ready_d    = 1'b0;
                    loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
                end else begin
                    dom_rst_d = dom_rst_q & ~stage_hit;
                    if (cnt_q == STAGE_END) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (!all_locked) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    pll_rst_d  = '1;
                    dom_rst_d  = '1;
                    ready_d    = 1'b0;
                    loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    assign pllRstOut      = pll_rst_q;
    assign domRstOut      = dom_rst_q;
    assign allReadyOut    = ready_q;
    assign lockLossCntOut = loss_cnt_q;
    assign timeoutCntOut  = to_cnt_q;
    assign stateOut       = state_q;

endmodule
`default_nettype wire
